// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
// Module parameters default to these values and may override them.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // A modulus of 1 still needs a 1-bit counter register.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and sampled by the
// tile address generator and video output stage.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_ce;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_start;
  logic   frame_start;

  modport master (
    output pix_ce, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    input pix_ce, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_counter.sv
// Modulo-MOD counter that advances on en and flags the cycle it wraps to 0.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;

  assign wrap  = en && (r_count == W'(MOD - 1));
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (wrap) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: pixel-rate enable, pixel coordinates,
// syncs, video_on and line/frame strobes, all registered with zero skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam logic [10:0] H_TOTAL_11 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL_11 = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int H_TOT   = int'(H_TOTAL_11);
  localparam int V_TOT   = int'(V_TOTAL_11);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int DIV_W   = cnt_width(CLK_DIV);

  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
  end

  function automatic logic in_win(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  logic [DIV_W-1:0] w_div_unused;
  logic             w_div_wrap;
  coord_t           w_x;
  coord_t           w_y;
  logic             w_h_wrap;
  logic             w_v_wrap;
  coord_t           w_x_nxt;
  coord_t           w_y_nxt;

  logic r_ce;
  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  logic r_line_start;
  logic r_frame_start;

  mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (w_div_unused),
    .wrap  (w_div_wrap)
  );

  // Pixel counters step at the end of each pix_ce cycle.
  mod_counter #(.MOD(H_TOT), .W(COORD_W)) u_h (
    .clk   (clk),
    .rst   (rst),
    .en    (r_ce),
    .count (w_x),
    .wrap  (w_h_wrap)
  );

  mod_counter #(.MOD(V_TOT), .W(COORD_W)) u_v (
    .clk   (clk),
    .rst   (rst),
    .en    (w_h_wrap),
    .count (w_y),
    .wrap  (w_v_wrap)
  );

  // Decode from next-state coordinates so registered outputs line up with the counters.
  always_comb begin
    w_x_nxt = w_x;
    w_y_nxt = w_y;
    if (r_ce) begin
      w_x_nxt = w_h_wrap ? '0 : w_x + 10'd1;
    end
    if (w_h_wrap) begin
      w_y_nxt = w_v_wrap ? '0 : w_y + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_ce          <= w_div_wrap;
      r_hsync       <= in_win(w_x_nxt, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= in_win(w_y_nxt, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  assign vga.pix_ce      = r_ce;
  assign vga.pixel_x     = w_x;
  assign vga.pixel_y     = w_y;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video_on;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance (CLK_DIV=4) and a
// small-raster instance (CLK_DIV=1, active-high syncs) for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b)
  );

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ls;
    logic       fs;
  } outs_t;

  typedef struct {
    string name;
    bit    b;
    int    k;
    outs_t exp;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  k_a      = 0;
  int  k_b      = 0;
  bit  chk_en   = 1'b0;

  // Cycles since the last clock edge that sampled reset.
  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
  end

  // Reference: position follows from the number of pixel enables consumed.
  function automatic outs_t model(input int k, input bit b);
    outs_t m;
    int d, h, v, ha, hs0, hs1, va, vs0, vs1, n, px, py;
    bit pol, step;
    if (!b) begin
      d = 4; h = 800; v = 525; ha = 640; hs0 = 656; hs1 = 752;
      va = 480; vs0 = 490; vs1 = 492; pol = 1'b0;
    end else begin
      d = 1; h = 25; v = 13; ha = 16; hs0 = 18; hs1 = 22;
      va = 8; vs0 = 9; vs1 = 11; pol = 1'b1;
    end
    n    = (k == 0) ? 0 : (k - 1) / d;
    step = (k > d) && ((k - 1) % d == 0);
    px   = n % h;
    py   = (n / h) % v;
    m.ce = (k >= d) && (k % d == 0);
    m.x  = 10'(px);
    m.y  = 10'(py);
    m.hs = (px >= hs0 && px < hs1) ? pol : ~pol;
    m.vs = (py >= vs0 && py < vs1) ? pol : ~pol;
    m.vo = (px < ha) && (py < va);
    m.ls = step && (px == 0);
    m.fs = step && (n % (h * v) == 0);
    return m;
  endfunction

  function automatic outs_t sample(input bit b);
    outs_t s;
    if (!b) begin
      s.ce = if_a.pix_ce; s.x = if_a.pixel_x; s.y = if_a.pixel_y;
      s.hs = if_a.hsync;  s.vs = if_a.vsync;  s.vo = if_a.video_on;
      s.ls = if_a.line_start; s.fs = if_a.frame_start;
    end else begin
      s.ce = if_b.pix_ce; s.x = if_b.pixel_x; s.y = if_b.pixel_y;
      s.hs = if_b.hsync;  s.vs = if_b.vsync;  s.vo = if_b.video_on;
      s.ls = if_b.line_start; s.fs = if_b.frame_start;
    end
    return s;
  endfunction

  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got ce=%0b x=%0d y=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b | want ce=%0b x=%0d y=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b",
               name, act.ce, act.x, act.y, act.hs, act.vs, act.vo, act.ls, act.fs,
               exp.ce, exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_outs("model_a", sample(1'b0), model(k_a, 1'b0));
      check_outs("model_b", sample(1'b1), model(k_b, 1'b1));
    end
  end

  function automatic vec_t mk(input string name, input bit b, input int k,
                              input bit ce, input int x, input int y, input bit hs,
                              input bit vs, input bit vo, input bit ls, input bit fs);
    vec_t t;
    t.name = name; t.b = b; t.k = k;
    t.exp.ce = ce; t.exp.x = 10'(x); t.exp.y = 10'(y);
    t.exp.hs = hs; t.exp.vs = vs; t.exp.vo = vo; t.exp.ls = ls; t.exp.fs = fs;
    return t;
  endfunction

  task automatic pulse_reset(input bit b, input int n);
    @(negedge clk);
    if (!b) rst_a = 1'b1; else rst_b = 1'b1;
    repeat (n) @(negedge clk);
    if (!b) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int kk, guard, t0, t1, n_ce, n_ls, n_fs;
    bit found;

    vecs.push_back(mk("a_rst",      0, 0,    0,   0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_ce_first", 0, 4,    1,   0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_x1",       0, 5,    0,   1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_ce_second",0, 8,    1,   1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_x639",     0, 2557, 0, 639, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_x640",     0, 2561, 0, 640, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("a_x655",     0, 2624, 1, 655, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("a_hs_on",    0, 2625, 0, 656, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("a_hs_last",  0, 3005, 0, 751, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("a_hs_off",   0, 3009, 0, 752, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("a_x799",     0, 3197, 0, 799, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("a_line",     0, 3201, 0,   0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk("a_line_end", 0, 3202, 0,   0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk("b_rst",      1, 0,    0,   0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("b_ce_first", 1, 1,    1,   0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("b_x1",       1, 2,    1,   1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("b_x16",      1, 17,   1,  16, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b_hs_on",    1, 19,   1,  18, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("b_hs_off",   1, 23,   1,  22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b_line",     1, 26,   1,   0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk("b_y8",       1, 201,  1,   0, 8, 0, 0, 0, 1, 0));
    vecs.push_back(mk("b_vs_on",    1, 226,  1,   0, 9, 0, 1, 0, 1, 0));
    vecs.push_back(mk("b_vs_last",  1, 275,  1,  24, 10, 0, 1, 0, 0, 0));
    vecs.push_back(mk("b_vs_off",   1, 276,  1,   0, 11, 0, 0, 0, 1, 0));
    vecs.push_back(mk("b_last",     1, 325,  1,  24, 12, 0, 0, 0, 0, 0));
    vecs.push_back(mk("b_frame",    1, 326,  1,   0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk("b_frame_end",1, 327,  1,   1, 0, 0, 0, 1, 0, 0));

    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1'b1;
    repeat (100) @(negedge clk);

    // Table vectors: each DUT reset for 3 clks mid-line, then walked forward.
    for (int s = 0; s < 2; s++) begin
      pulse_reset(s[0], 3);
      foreach (vecs[i]) begin
        if (vecs[i].b == s[0]) begin
          guard = 0;
          kk = s[0] ? k_b : k_a;
          while (kk != vecs[i].k && guard < 4000) begin
            @(negedge clk);
            kk = s[0] ? k_b : k_a;
            guard++;
          end
          if (kk != vecs[i].k) timeout(vecs[i].name);
          else check_outs(vecs[i].name, sample(s[0]), vecs[i].exp);
        end
      end
    end

    // pix_ce period on the CLK_DIV=4 instance.
    t0 = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_a.pix_ce) begin
        if (t0 >= 0) check_int("a_ce_period", c - t0, 4);
        t0 = c;
      end
    end

    // Mid-frame reset on the small raster at (20,10).
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (if_b.pixel_x == 10'd20 && if_b.pixel_y == 10'd10) found = 1'b1;
    end
    if (!found) timeout("b_midframe_wait");
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check_outs("b_midrst", sample(1'b1), mk("", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0).exp);
    @(negedge clk);
    check_outs("b_resume0", sample(1'b1), mk("", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0).exp);
    @(negedge clk);
    check_outs("b_resume1", sample(1'b1), mk("", 1, 0, 1, 1, 0, 0, 0, 1, 0, 0).exp);

    // Totals over one frame (small raster) and one line (full size).
    for (int s = 0; s < 2; s++) begin
      pulse_reset(s[0], 1);
      @(negedge clk);
      n_ce = 0; n_ls = 0; n_fs = 0;
      t1 = s[0] ? 325 : 3200;
      for (int c = 0; c < t1; c++) begin
        @(negedge clk);
        if (s[0]) begin
          n_ce += int'(if_b.pix_ce); n_ls += int'(if_b.line_start); n_fs += int'(if_b.frame_start);
        end else begin
          n_ce += int'(if_a.pix_ce); n_ls += int'(if_a.line_start); n_fs += int'(if_a.frame_start);
        end
      end
      if (s[0]) begin
        check_int("b_frame_ce", n_ce, 325);
        check_int("b_frame_lines", n_ls, 13);
        check_int("b_frame_frames", n_fs, 1);
      end else begin
        check_int("a_line_ce", n_ce, 800);
        check_int("a_line_lines", n_ls, 1);
      end
    end

    // Random resets, checked every cycle against the reference.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      pulse_reset($urandom_range(0, 1) == 1, int'($urandom_range(1, 3)));
    end
    repeat (400) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
